// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt resolver: handshake FSM encoding,
// channel-ID width helper and the spurious vector ID.
// Latency: n/a (definitions only). Backpressure: n/a.
package irq_pkg;

  // Acknowledge handshake: IDLE waits for the first INTA pulse, ACK1 waits
  // for the second, ACK2 is the single cycle in which the vector is valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } irq_state_t;

  localparam int IRQ_N_DEFAULT = 8;

  // Width of a binary channel ID. A 2-channel build still needs one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // ID reported when an acknowledge finds nothing pending.
  function automatic int spurious_vec(input int n);
    return n - 1;
  endfunction

  localparam int SPURIOUS_VEC_DEFAULT = IRQ_N_DEFAULT - 1;

endpackage

// File: rtl/prio_onehot.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: none.
// Ports: req (request vector), ptr (highest-priority channel) ->
//        onehot (winner), id (binary winner), any (some request set).
module prio_onehot
  import irq_pkg::*;
#(
  parameter int N    = IRQ_N_DEFAULT,
  parameter int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] id,
  output logic            any
);

  logic [ID_W-1:0] idx;

  // Scan from the lowest priority up so the highest-priority hit is the
  // last assignment. N is a power of two, so ID_W-bit addition wraps mod N.
  always_comb begin
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    idx    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      idx = ptr + ID_W'(j);
      if (req[idx]) begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        id          = idx;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_resolver.sv
// Interrupt resolver: edge-latched IRR, masking, priority pick, two-pulse
// INTA handshake moving the winner into the one-hot ISR.
// Latency: ir_in edge -> irr 1 cycle, int_out 2 cycles; 2nd ack -> vec_valid
// 1 cycle. Backpressure: none; ack in ACK2 is ignored.
// Optional feature macro: IRQ_ROTATE_EN (rotating priority pointer). Without
// it the pointer is tied to 0 (channel 0 highest) and rotate_en is ignored.
// Ports: clk/rst; ir_in, imr (requests, mask); ack, eoi, eoi_specific,
//        eoi_id, rotate_en (CPU side); int_out, vec_valid, vec_id,
//        spurious, irr, isr (status/outputs).
module irq_resolver
  import irq_pkg::*;
#(
  parameter int N    = IRQ_N_DEFAULT,
  parameter int ID_W = id_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    ir_in,
  input  logic [N-1:0]    imr,
  input  logic            ack,
  input  logic            eoi,
  input  logic            eoi_specific,
  input  logic [ID_W-1:0] eoi_id,
  input  logic            rotate_en,
  output logic            int_out,
  output logic            vec_valid,
  output logic [ID_W-1:0] vec_id,
  output logic            spurious,
  output logic [N-1:0]    irr,
  output logic [N-1:0]    isr
);

  localparam logic [ID_W-1:0] SPUR_ID = ID_W'(spurious_vec(N));

  irq_state_t      state, state_n;
  logic [N-1:0]    ir_prev, ir_rise, req;
  logic [N-1:0]    req_oh, isr_oh, eoi_clr, ack_set;
  logic [ID_W-1:0] req_id, isr_id, p;
  logic [ID_W-1:0] req_rank, isr_rank;
  logic            req_any, isr_any, take, int_n;

  assign ir_rise = ir_in & ~ir_prev;
  assign req     = irr & ~imr;

  prio_onehot #(.N(N), .ID_W(ID_W)) u_req_pick (
    .req    (req),
    .ptr    (p),
    .onehot (req_oh),
    .id     (req_id),
    .any    (req_any)
  );

  prio_onehot #(.N(N), .ID_W(ID_W)) u_isr_pick (
    .req    (isr),
    .ptr    (p),
    .onehot (isr_oh),
    .id     (isr_id),
    .any    (isr_any)
  );

  // First acknowledge captures the winner.
  assign take    = (state == IDLE) && ack;
  assign ack_set = (take && req_any) ? req_oh : '0;

  // EOI resolves against the current (pre-ack) ISR.
  always_comb begin
    eoi_clr = '0;
    if (eoi) begin
      if (eoi_specific) begin
        if (isr[eoi_id]) eoi_clr[eoi_id] = 1'b1;
      end else begin
        eoi_clr = isr_oh;
      end
    end
  end

  // Rank relative to the pointer: smaller rank = higher priority. Wraps mod N.
  assign req_rank = req_id - p;
  assign isr_rank = isr_id - p;
  assign int_n    = req_any && (!isr_any || (req_rank < isr_rank));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ack) state_n = ACK1;
      ACK1:    if (ack) state_n = ACK2;
      ACK2:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_prev   <= '0;
      irr       <= '0;
      isr       <= '0;
      int_out   <= 1'b0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
      spurious  <= 1'b0;
    end else begin
      ir_prev   <= ir_in;
      // A new edge on a channel being acknowledged wins over the clear.
      irr       <= (irr & ~ack_set) | ir_rise;
      // Set after clear: an ack set on the EOI target survives.
      isr       <= (isr & ~eoi_clr) | ack_set;
      int_out   <= int_n;
      vec_valid <= (state == ACK1) && ack;
      if (take) begin
        vec_id   <= req_any ? req_id : SPUR_ID;
        spurious <= !req_any;
      end
    end
  end

`ifdef IRQ_ROTATE_EN
  logic [ID_W-1:0] eoi_k;
  logic            eoi_hit;

  assign eoi_hit = |eoi_clr;
  assign eoi_k   = eoi_specific ? eoi_id : isr_id;

  // The level just retired becomes lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (eoi_hit && rotate_en) begin
      p <= eoi_k + 1'b1;
    end
  end
`else
  logic unused_rotate;

  assign p             = '0;
  assign unused_rotate = rotate_en;
`endif

endmodule
